// File: rtl/lsb_embed_ctrl.sv
// Job sequencer for the LSB bit changer: pairs one message chunk with each audio frame,
// launches the changer, waits for its ready edge and emits the resulting stego frame.
module lsb_embed_ctrl #(
  parameter int BPS        = 16,
  parameter int FRAME_SIZE = 8,
  parameter int LEN_W      = 16,
  parameter int TIMEOUT    = 15
) (
  input  logic                       in_clk,
  input  logic                       in_rst,
  input  logic                       in_start,
  input  logic [LEN_W-1:0]           in_msg_len,
  input  logic                       in_frame_valid,
  input  logic [FRAME_SIZE*BPS-1:0]  in_frame,
  output logic                       out_frame_ready,
  input  logic                       in_msg_valid,
  input  logic [FRAME_SIZE-1:0]      in_msg,
  output logic                       out_msg_ready,
  output logic                       out_bc_enable,
  output logic [FRAME_SIZE*BPS-1:0]  out_bc_frame,
  output logic [FRAME_SIZE-1:0]      out_bc_message,
  input  logic [FRAME_SIZE*BPS-1:0]  in_bc_frame,
  input  logic                       in_bc_ready,
  output logic                       out_frame_valid,
  output logic [FRAME_SIZE*BPS-1:0]  out_frame,
  output logic                       out_busy,
  output logic                       out_done,
  output logic                       out_error,
  output logic [LEN_W-1:0]           out_count
);

  localparam int FW = FRAME_SIZE * BPS;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_LAUNCH = 3'd2,
    S_WAIT   = 3'd3,
    S_EMIT   = 3'd4
  } state_t;

  state_t             state_r;
  logic [LEN_W-1:0]   len_r;
  logic [FW-1:0]      frame_r;
  logic [FRAME_SIZE-1:0] msg_r;
  logic               have_frame_r;
  logic               have_msg_r;
  logic               bc_ready_prev_r;
  logic [TW-1:0]      wait_cnt_r;

  logic frame_hs_s;
  logic msg_hs_s;
  logic got_frame_s;
  logic got_msg_s;
  logic bc_edge_s;

  assign frame_hs_s  = in_frame_valid & out_frame_ready;
  assign msg_hs_s    = in_msg_valid & out_msg_ready;
  assign got_frame_s = have_frame_r | frame_hs_s;
  assign got_msg_s   = have_msg_r | msg_hs_s;
  // Only a fresh rising edge counts, so a ready still high from the previous launch is ignored.
  assign bc_edge_s   = in_bc_ready & ~bc_ready_prev_r;

  // Held registers feed the changer directly and only change in FETCH.
  assign out_bc_frame   = frame_r;
  assign out_bc_message = msg_r;

  // Job sequencer state machine with registered outputs.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_r         <= S_IDLE;
      len_r           <= '0;
      frame_r         <= '0;
      msg_r           <= '0;
      have_frame_r    <= 1'b0;
      have_msg_r      <= 1'b0;
      bc_ready_prev_r <= 1'b0;
      wait_cnt_r      <= '0;
      out_frame_ready <= 1'b0;
      out_msg_ready   <= 1'b0;
      out_bc_enable   <= 1'b0;
      out_frame_valid <= 1'b0;
      out_frame       <= '0;
      out_busy        <= 1'b0;
      out_done        <= 1'b0;
      out_error       <= 1'b0;
      out_count       <= '0;
    end else begin
      out_bc_enable   <= 1'b0;
      out_frame_valid <= 1'b0;
      out_done        <= 1'b0;
      bc_ready_prev_r <= in_bc_ready;
      case (state_r)
        S_IDLE: begin
          if (in_start) begin
            len_r     <= in_msg_len;
            out_count <= '0;
            out_error <= 1'b0;
            if (in_msg_len == '0) begin
              out_done <= 1'b1;
            end else begin
              state_r         <= S_FETCH;
              out_busy        <= 1'b1;
              out_frame_ready <= 1'b1;
              out_msg_ready   <= 1'b1;
              have_frame_r    <= 1'b0;
              have_msg_r      <= 1'b0;
            end
          end
        end
        S_FETCH: begin
          if (frame_hs_s) begin
            frame_r         <= in_frame;
            have_frame_r    <= 1'b1;
            out_frame_ready <= 1'b0;
          end
          if (msg_hs_s) begin
            msg_r         <= in_msg;
            have_msg_r    <= 1'b1;
            out_msg_ready <= 1'b0;
          end
          if (got_frame_s && got_msg_s) begin
            state_r       <= S_LAUNCH;
            out_bc_enable <= 1'b1;
          end
        end
        S_LAUNCH: begin
          state_r    <= S_WAIT;
          wait_cnt_r <= '0;
        end
        S_WAIT: begin
          if (bc_edge_s) begin
            out_frame       <= in_bc_frame;
            out_frame_valid <= 1'b1;
            out_count       <= out_count + LEN_W'(1);
            state_r         <= S_EMIT;
          end else if (wait_cnt_r == TW'(TIMEOUT)) begin
            out_error <= 1'b1;
            out_busy  <= 1'b0;
            state_r   <= S_IDLE;
          end else begin
            wait_cnt_r <= wait_cnt_r + TW'(1);
          end
        end
        S_EMIT: begin
          if (out_count == len_r) begin
            out_done <= 1'b1;
            out_busy <= 1'b0;
            state_r  <= S_IDLE;
          end else begin
            state_r         <= S_FETCH;
            out_frame_ready <= 1'b1;
            out_msg_ready   <= 1'b1;
            have_frame_r    <= 1'b0;
            have_msg_r      <= 1'b0;
          end
        end
        default: begin
          state_r         <= S_IDLE;
          out_busy        <= 1'b0;
          out_frame_ready <= 1'b0;
          out_msg_ready   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsb_embed_ctrl.sv
// Directed bench for lsb_embed_ctrl with a 3-cycle bit changer model whose ready
// stays high until the next launch.
module tb_lsb_embed_ctrl;
  localparam int BPS = 16;
  localparam int FS  = 8;
  localparam int LW  = 16;
  localparam int TO  = 15;
  localparam int FW  = FS * BPS;

  logic          clk = 1'b0;
  logic          in_rst, in_start;
  logic [LW-1:0] in_msg_len;
  logic          in_frame_valid, out_frame_ready;
  logic [FW-1:0] in_frame;
  logic          in_msg_valid, out_msg_ready;
  logic [FS-1:0] in_msg;
  logic          out_bc_enable;
  logic [FW-1:0] out_bc_frame, in_bc_frame, out_frame;
  logic [FS-1:0] out_bc_message;
  logic          in_bc_ready, out_frame_valid, out_busy, out_done, out_error;
  logic [LW-1:0] out_count;

  always #5 clk = ~clk;

  lsb_embed_ctrl #(.BPS(BPS), .FRAME_SIZE(FS), .LEN_W(LW), .TIMEOUT(TO)) dut (
    .in_clk(clk), .in_rst(in_rst), .in_start(in_start), .in_msg_len(in_msg_len),
    .in_frame_valid(in_frame_valid), .in_frame(in_frame), .out_frame_ready(out_frame_ready),
    .in_msg_valid(in_msg_valid), .in_msg(in_msg), .out_msg_ready(out_msg_ready),
    .out_bc_enable(out_bc_enable), .out_bc_frame(out_bc_frame), .out_bc_message(out_bc_message),
    .in_bc_frame(in_bc_frame), .in_bc_ready(in_bc_ready), .out_frame_valid(out_frame_valid),
    .out_frame(out_frame), .out_busy(out_busy), .out_done(out_done), .out_error(out_error),
    .out_count(out_count)
  );

  // Bit changer model: ready rises 3 cycles after the enable cycle, drops on the next enable.
  logic [1:0] bc_cnt = 2'd0;
  logic       bc_rdy = 1'b0;
  logic       bc_mute;
  always @(posedge clk) begin
    if (out_bc_enable) begin
      bc_cnt <= 2'd2;
      bc_rdy <= 1'b0;
    end else if (bc_cnt != 2'd0) begin
      bc_cnt <= bc_cnt - 2'd1;
      if (bc_cnt == 2'd1) bc_rdy <= 1'b1;
    end
  end
  assign in_bc_ready = bc_rdy & ~bc_mute;

  function automatic logic [FW-1:0] lsb_embed(input logic [FW-1:0] f, input logic [FS-1:0] m);
    logic [FW-1:0] r;
    r = f;
    for (int k = 0; k < FS; k++) r[k*BPS] = m[k];
    return r;
  endfunction
  assign in_bc_frame = lsb_embed(out_bc_frame, out_bc_message);

  // Output monitor, sampled on the falling edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int vld_n = 0, done_n = 0, en_n = 0, done_cyc_last = 0, err_rise_cyc = -1;
  logic err_prev = 1'b0;
  logic [FW-1:0] vld_frame [0:63];
  int vld_cyc [0:63];
  int en_cyc  [0:63];
  always @(negedge clk) begin
    if (out_frame_valid && vld_n < 64) begin
      vld_frame[vld_n] = out_frame;
      vld_cyc[vld_n] = cyc;
      vld_n++;
    end
    if (out_done) begin
      done_n++;
      done_cyc_last = cyc;
    end
    if (out_bc_enable && en_n < 64) begin
      en_cyc[en_n] = cyc;
      en_n++;
    end
    if (out_error && !err_prev) err_rise_cyc = cyc;
    err_prev = out_error;
  end

  int tests = 0, fails = 0;
  logic [FW-1:0] frm_q[$];
  logic [FS-1:0] msg_q[$];
  int frm_start = 0, msg_start = 0;

  task automatic drive_src();
    in_frame_valid = (frm_q.size() != 0) && (cyc >= frm_start);
    in_frame       = (frm_q.size() != 0) ? frm_q[0] : '0;
    in_msg_valid   = (msg_q.size() != 0) && (cyc >= msg_start);
    in_msg         = (msg_q.size() != 0) ? msg_q[0] : '0;
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      bit fh, mh;
      @(negedge clk);
      fh = in_frame_valid && out_frame_ready && !in_rst;
      mh = in_msg_valid && out_msg_ready && !in_rst;
      @(posedge clk);
      #1;
      if (fh) void'(frm_q.pop_front());
      if (mh) void'(msg_q.pop_front());
      drive_src();
    end
  endtask

  task automatic start_job(input logic [LW-1:0] len);
    in_start = 1'b1;
    in_msg_len = len;
    run_cycles(1);
    in_start = 1'b0;
  endtask

  task automatic test_reset();
    in_rst = 1'b1;
    run_cycles(3);
    tests++;
    if ({out_busy, out_done, out_error, out_frame_valid, out_bc_enable, out_frame_ready, out_msg_ready} !== 7'd0) begin
      fails++;
      $display("FAIL reset_flags: got %b expected 0000000",
               {out_busy, out_done, out_error, out_frame_valid, out_bc_enable, out_frame_ready, out_msg_ready});
    end
    tests++;
    if (out_count !== 16'd0 || out_frame !== '0 || out_bc_frame !== '0 || out_bc_message !== 8'd0) begin
      fails++;
      $display("FAIL reset_data: got count=%h frame=%h bc_frame=%h bc_msg=%h expected all 0",
               out_count, out_frame, out_bc_frame, out_bc_message);
    end
    in_rst = 1'b0;
    run_cycles(2);
  endtask

  task automatic test_single();
    int v0, d0;
    logic [FW-1:0] exp_f;
    v0 = vld_n; d0 = done_n;
    frm_q = {{8{16'hFFFF}}}; msg_q = {8'h00};
    frm_start = cyc; msg_start = cyc;
    drive_src();
    start_job(16'd1);
    for (int i = 0; i < 30 && done_n == d0; i++) run_cycles(1);
    run_cycles(2);
    exp_f = {8{16'hFFFE}};
    tests++;
    if (vld_n - v0 != 1) begin fails++; $display("FAIL single_pulses: got %0d expected 1", vld_n - v0); end
    tests++;
    if (vld_frame[v0] !== exp_f) begin fails++; $display("FAIL single_frame: got %h expected %h", vld_frame[v0], exp_f); end
    tests++;
    if (done_n - d0 != 1 || done_cyc_last - vld_cyc[v0] != 1) begin
      fails++;
      $display("FAIL single_done: got %0d pulses at offset %0d expected 1 at offset 1", done_n - d0, done_cyc_last - vld_cyc[v0]);
    end
    tests++;
    if (out_count !== 16'd1 || out_busy !== 1'b0) begin
      fails++;
      $display("FAIL single_count: got count=%0d busy=%b expected 1 0", out_count, out_busy);
    end
  endtask

  task automatic test_back_to_back();
    int v0, d0, e0;
    logic [FW-1:0] exp_f [0:2];
    v0 = vld_n; d0 = done_n; e0 = en_n;
    exp_f[0] = {16'h1, 16'h0, 16'h1, 16'h0, 16'h0, 16'h1, 16'h0, 16'h1};
    exp_f[1] = {16'h0, 16'h0, 16'h1, 16'h1, 16'h1, 16'h1, 16'h0, 16'h0};
    exp_f[2] = {8{16'h0001}};
    frm_q = {128'd0, 128'd0, 128'd0}; msg_q = {8'hA5, 8'h3C, 8'hFF};
    frm_start = cyc; msg_start = cyc;
    drive_src();
    start_job(16'd3);
    for (int i = 0; i < 60 && done_n == d0; i++) run_cycles(1);
    run_cycles(4);
    tests++;
    if (vld_n - v0 != 3) begin fails++; $display("FAIL b2b_pulses: got %0d expected 3", vld_n - v0); end
    for (int k = 0; k < 3; k++) begin
      tests++;
      if (vld_frame[v0+k] !== exp_f[k]) begin
        fails++;
        $display("FAIL b2b_frame%0d: got %h expected %h", k, vld_frame[v0+k], exp_f[k]);
      end
    end
    for (int k = 1; k < 3; k++) begin
      tests++;
      if (vld_cyc[v0+k] - vld_cyc[v0+k-1] != 6) begin
        fails++;
        $display("FAIL b2b_spacing%0d: got %0d expected 6", k, vld_cyc[v0+k] - vld_cyc[v0+k-1]);
      end
    end
    tests++;
    if (done_n - d0 != 1 || en_n - e0 != 3 || out_count !== 16'd3) begin
      fails++;
      $display("FAIL b2b_totals: got done=%0d launches=%0d count=%0d expected 1 3 3", done_n - d0, en_n - e0, out_count);
    end
  endtask

  task automatic test_frame_early();
    int v0, d0, e0;
    logic [FW-1:0] exp_f;
    v0 = vld_n; d0 = done_n; e0 = en_n;
    frm_q = {{8{16'h1234}}}; msg_q = {8'h0F};
    frm_start = cyc; msg_start = cyc + 6;
    drive_src();
    start_job(16'd1);
    run_cycles(3);
    tests++;
    if (out_frame_ready !== 1'b0 || out_msg_ready !== 1'b1 || en_n != e0) begin
      fails++;
      $display("FAIL early_hold: got frame_ready=%b msg_ready=%b launches=%0d expected 0 1 0",
               out_frame_ready, out_msg_ready, en_n - e0);
    end
    for (int i = 0; i < 40 && done_n == d0; i++) run_cycles(1);
    run_cycles(2);
    exp_f = {{4{16'h1234}}, {4{16'h1235}}};
    tests++;
    if (en_n - e0 != 1 || vld_n - v0 != 1) begin
      fails++;
      $display("FAIL early_launch: got launches=%0d pulses=%0d expected 1 1", en_n - e0, vld_n - v0);
    end
    tests++;
    if (vld_frame[v0] !== exp_f) begin fails++; $display("FAIL early_frame: got %h expected %h", vld_frame[v0], exp_f); end
  endtask

  task automatic test_timeout();
    int v0, d0, e0;
    v0 = vld_n; d0 = done_n; e0 = en_n;
    bc_mute = 1'b1;
    frm_q = {128'd7, 128'd9}; msg_q = {8'h11, 8'h22};
    frm_start = cyc; msg_start = cyc;
    drive_src();
    start_job(16'd2);
    for (int i = 0; i < 60 && out_error !== 1'b1; i++) run_cycles(1);
    run_cycles(2);
    tests++;
    if (out_error !== 1'b1) begin fails++; $display("FAIL timeout_flag: got %b expected 1", out_error); end
    tests++;
    if (en_n - e0 != 1 || err_rise_cyc - en_cyc[e0] != TO + 2) begin
      fails++;
      $display("FAIL timeout_latency: got launches=%0d offset=%0d expected 1 %0d", en_n - e0, err_rise_cyc - en_cyc[e0], TO + 2);
    end
    tests++;
    if (done_n != d0 || vld_n != v0 || out_busy !== 1'b0) begin
      fails++;
      $display("FAIL timeout_abort: got done=%0d pulses=%0d busy=%b expected 0 0 0", done_n - d0, vld_n - v0, out_busy);
    end
    bc_mute = 1'b0;
    frm_q.delete(); msg_q.delete();
    drive_src();
    start_job(16'd0);
    run_cycles(2);
    tests++;
    if (out_error !== 1'b0 || done_n - d0 != 1 || en_n - e0 != 1) begin
      fails++;
      $display("FAIL timeout_clear: got error=%b done=%0d launches=%0d expected 0 1 1", out_error, done_n - d0, en_n - e0);
    end
  endtask

  task automatic test_reset_mid();
    int v1, d0, e0;
    d0 = done_n; e0 = en_n;
    frm_q = {128'd0, 128'd0, 128'd0}; msg_q = {8'h55, 8'hAA, 8'h0F};
    frm_start = cyc; msg_start = cyc;
    drive_src();
    start_job(16'd3);
    for (int i = 0; i < 40 && en_n - e0 < 2; i++) run_cycles(1);
    tests++;
    if (en_n - e0 != 2) begin fails++; $display("FAIL mid_second_launch: got %0d expected 2", en_n - e0); end
    in_rst = 1'b1;
    frm_q.delete(); msg_q.delete();
    drive_src();
    run_cycles(1);
    tests++;
    if ({out_busy, out_done, out_error, out_frame_valid, out_bc_enable, out_frame_ready, out_msg_ready} !== 7'd0) begin
      fails++;
      $display("FAIL mid_flags: got %b expected 0000000",
               {out_busy, out_done, out_error, out_frame_valid, out_bc_enable, out_frame_ready, out_msg_ready});
    end
    tests++;
    if (out_count !== 16'd0 || out_frame !== '0 || out_bc_frame !== '0 || out_bc_message !== 8'd0) begin
      fails++;
      $display("FAIL mid_data: got count=%h frame=%h bc_msg=%h expected all 0", out_count, out_frame, out_bc_message);
    end
    in_rst = 1'b0;
    v1 = vld_n;
    run_cycles(8);
    tests++;
    if (vld_n != v1 || out_busy !== 1'b0) begin
      fails++;
      $display("FAIL mid_late_ready: got pulses=%0d busy=%b expected 0 0", vld_n - v1, out_busy);
    end
    start_job(16'd0);
    run_cycles(2);
    tests++;
    if (done_n - d0 != 1 || en_n - e0 != 2) begin
      fails++;
      $display("FAIL mid_empty_job: got done=%0d launches=%0d expected 1 2", done_n - d0, en_n - e0);
    end
  endtask

  initial begin
    in_rst = 1'b1; in_start = 1'b0; in_msg_len = '0; bc_mute = 1'b0;
    drive_src();
    test_reset();
    test_single();
    test_back_to_back();
    test_frame_early();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
